// File: rtl/stack_op_sequencer_if.sv
// Command/response port of the stack-op sequencer.
//   cmd_valid/cmd_ready : command handshake, accepted when both high on a rising edge
//   cmd_op              : 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 NOT, 7 TOS
//   cmd_imm             : PUSH operand
//   rsp_valid           : one-cycle response pulse
//   rsp_err             : qualifies rsp_valid, command was rejected
//   rsp_data            : result / popped / peeked value, 0 on error
// master = command issuer, slave = sequencer.
interface stack_op_sequencer_if #(
  parameter int unsigned Width = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [Width-1:0] cmd_imm;
  logic             rsp_valid;
  logic             rsp_err;
  logic [Width-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_imm,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm,
    output cmd_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// Command front-end for the 8-bit LIFO stack of the stack-based multi-cycle MIPS datapath.
// Takes one stack-machine command at a time, sequences the stack's push/pop/tos strobes,
// tracks depth locally to reject underflow/overflow, and returns one response per command.
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset (the stack is cleared by the same reset)
//   bus_if      command/response port (slave side)
//   stk_push_o  stack push strobe, stk_din_o carries the value
//   stk_pop_o   stack pop strobe
//   stk_tos_o   stack top-of-stack read strobe
//   stk_din_o   stack write data, 0 whenever not pushing
//   stk_dout_i  stack registered read data, valid the cycle after pop/tos
//   depth_o     number of entries currently held
module stack_op_sequencer #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Depth  = 31,
  parameter int unsigned DepthW = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  stack_op_sequencer_if.slave bus_if,
  output logic                stk_push_o,
  output logic                stk_pop_o,
  output logic                stk_tos_o,
  output logic [Width-1:0]    stk_din_o,
  input  logic [Width-1:0]    stk_dout_i,
  output logic [DepthW-1:0]   depth_o
);

  localparam logic [2:0] OpPush = 3'd0;
  localparam logic [2:0] OpPop  = 3'd1;
  localparam logic [2:0] OpAdd  = 3'd2;
  localparam logic [2:0] OpSub  = 3'd3;
  localparam logic [2:0] OpAnd  = 3'd4;
  localparam logic [2:0] OpOr   = 3'd5;
  localparam logic [2:0] OpNot  = 3'd6;
  localparam logic [2:0] OpTos  = 3'd7;

  localparam logic [DepthW-1:0] DepthFull = DepthW'(Depth);

  typedef enum logic [3:0] {
    StIdle,
    StPop1,
    StWait1,
    StPop2,
    StWait2,
    StPushR,
    StPeek,
    StPeekW,
    StDone,
    StErr
  } state_e;

  state_e              state_q, state_d;
  logic [DepthW-1:0]   depth_q, depth_d;
  logic [2:0]          op_q, op_d;
  logic [Width-1:0]    opb_q, opb_d;
  logic [Width-1:0]    res_q, res_d;
  logic [DepthW-1:0]   need_ops;

  // Operands each command consumes from the stack.
  always_comb begin
    unique case (bus_if.cmd_op)
      OpPush:              need_ops = DepthW'(0);
      OpPop, OpNot, OpTos: need_ops = DepthW'(1);
      default:             need_ops = DepthW'(2);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      depth_q <= '0;
      op_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      op_q    <= op_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    op_d    = op_q;
    opb_d   = opb_q;
    res_d   = res_q;

    unique case (state_q)
      StIdle: begin
        if (bus_if.cmd_valid) begin
          op_d = bus_if.cmd_op;
          if (depth_q < need_ops) begin
            state_d = StErr;
          end else if (bus_if.cmd_op == OpPush && depth_q == DepthFull) begin
            state_d = StErr;
          end else if (bus_if.cmd_op == OpPush) begin
            res_d   = bus_if.cmd_imm;
            state_d = StPushR;
          end else if (bus_if.cmd_op == OpTos) begin
            state_d = StPeek;
          end else begin
            state_d = StPop1;
          end
        end
      end

      StPop1: begin
        depth_d = depth_q - DepthW'(1);
        state_d = StWait1;
      end

      // First popped value is the former top (operand B).
      StWait1: begin
        opb_d = stk_dout_i;
        if (op_q == OpPop) begin
          res_d   = stk_dout_i;
          state_d = StDone;
        end else if (op_q == OpNot) begin
          res_d   = ~stk_dout_i;
          state_d = StPushR;
        end else begin
          state_d = StPop2;
        end
      end

      StPop2: begin
        depth_d = depth_q - DepthW'(1);
        state_d = StWait2;
      end

      // Operand A (older entry) is used straight from stk_dout_i; only the result is kept.
      StWait2: begin
        unique case (op_q)
          OpAdd:   res_d = stk_dout_i + opb_q;
          OpSub:   res_d = stk_dout_i - opb_q;
          OpAnd:   res_d = stk_dout_i & opb_q;
          OpOr:    res_d = stk_dout_i | opb_q;
          default: res_d = '0;
        endcase
        state_d = StPushR;
      end

      StPushR: begin
        depth_d = depth_q + DepthW'(1);
        state_d = StDone;
      end

      StPeek:  state_d = StPeekW;

      StPeekW: begin
        res_d   = stk_dout_i;
        state_d = StDone;
      end

      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    bus_if.cmd_ready = (state_q == StIdle);
    bus_if.rsp_valid = (state_q == StDone) || (state_q == StErr);
    bus_if.rsp_err   = (state_q == StErr);
    bus_if.rsp_data  = (state_q == StDone) ? res_q : '0;
    stk_push_o       = (state_q == StPushR);
    stk_pop_o        = (state_q == StPop1) || (state_q == StPop2);
    stk_tos_o        = (state_q == StPeek);
    stk_din_o        = (state_q == StPushR) ? res_q : '0;
    depth_o          = depth_q;
  end

  strobe_onehot0_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({stk_push_o, stk_pop_o, stk_tos_o}));

  din_quiet_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !stk_push_o |-> stk_din_o == '0);

  depth_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    depth_q <= DepthFull);

endmodule

// File: tb/tb_stack_op_sequencer.sv
module tb_stack_op_sequencer;
  localparam int W = 8;
  localparam logic [2:0] OpPush = 3'd0;
  localparam logic [2:0] OpPop  = 3'd1;
  localparam logic [2:0] OpAdd  = 3'd2;
  localparam logic [2:0] OpSub  = 3'd3;
  localparam logic [2:0] OpAnd  = 3'd4;
  localparam logic [2:0] OpOr   = 3'd5;
  localparam logic [2:0] OpNot  = 3'd6;
  localparam logic [2:0] OpTos  = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_op_sequencer_if #(.Width(W)) bus ();

  logic         stk_push, stk_pop, stk_tos;
  logic [W-1:0] stk_din;
  logic [W-1:0] stk_dout;
  logic [4:0]   depth;

  stack_op_sequencer #(.Width(W), .Depth(31), .DepthW(5)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus_if     (bus.slave),
    .stk_push_o (stk_push),
    .stk_pop_o  (stk_pop),
    .stk_tos_o  (stk_tos),
    .stk_din_o  (stk_din),
    .stk_dout_i (stk_dout),
    .depth_o    (depth)
  );

  // Behavioural LIFO standing in for the real stack: registered d_out, ignores push at 31.
  logic [W-1:0] smem [0:31];
  int           scnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt     <= 0;
      stk_dout <= '0;
    end else if (stk_push) begin
      if (scnt < 31) begin
        smem[scnt] <= stk_din;
        scnt       <= scnt + 1;
      end
    end else if (stk_pop) begin
      if (scnt > 0) begin
        stk_dout <= smem[scnt-1];
        scnt     <= scnt - 1;
      end
    end else if (stk_tos) begin
      if (scnt > 0) stk_dout <= smem[scnt-1];
    end
  end

  // Strobe counters and protocol-violation counter, sampled mid-cycle.
  int n_push = 0, n_pop = 0, n_tos = 0, n_viol = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      n_push += int'(stk_push);
      n_pop  += int'(stk_pop);
      n_tos  += int'(stk_tos);
      if ((int'(stk_push) + int'(stk_pop) + int'(stk_tos)) > 1) n_viol++;
      if (!stk_push && stk_din != '0) n_viol++;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a plain queue, top of stack at the back.
  logic [W-1:0] mstk [$];

  logic [W-1:0] last_data;
  logic         last_err;
  int           last_lat;

  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] imm, input bit garble);
    logic [W-1:0] a, b, r, e_data;
    logic         e_err;
    int           e_lat, e_push, e_pop, e_tos, w, cyc, p0, q0, t0;
    bit           got;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) check("ready_timeout", 32'd0, 32'd1);

    e_err = 1'b0; e_data = '0; e_lat = 1; e_push = 0; e_pop = 0; e_tos = 0;
    case (op)
      OpPush: begin
        if (mstk.size() >= 31) e_err = 1'b1;
        else begin
          mstk.push_back(imm); e_data = imm; e_lat = 2; e_push = 1;
        end
      end
      OpPop: begin
        if (mstk.size() < 1) e_err = 1'b1;
        else begin
          e_data = mstk.pop_back(); e_lat = 3; e_pop = 1;
        end
      end
      OpNot: begin
        if (mstk.size() < 1) e_err = 1'b1;
        else begin
          b = mstk.pop_back(); r = ~b; mstk.push_back(r);
          e_data = r; e_lat = 4; e_pop = 1; e_push = 1;
        end
      end
      OpTos: begin
        if (mstk.size() < 1) e_err = 1'b1;
        else begin
          e_data = mstk[$]; e_lat = 3; e_tos = 1;
        end
      end
      default: begin
        if (mstk.size() < 2) e_err = 1'b1;
        else begin
          b = mstk.pop_back();
          a = mstk.pop_back();
          case (op)
            OpAdd:   r = a + b;
            OpSub:   r = a - b;
            OpAnd:   r = a & b;
            default: r = a | b;
          endcase
          mstk.push_back(r);
          e_data = r; e_lat = 6; e_pop = 2; e_push = 1;
        end
      end
    endcase

    p0 = n_push; q0 = n_pop; t0 = n_tos;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_imm   = imm;
    @(posedge clk);
    #1;
    if (garble) begin
      bus.cmd_op  = 3'($urandom);
      bus.cmd_imm = W'($urandom);
    end else begin
      bus.cmd_valid = 1'b0;
    end

    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) got = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    last_data = bus.rsp_data;
    last_err  = bus.rsp_err;
    last_lat  = cyc;

    check("rsp_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(e_lat));
    check("rsp_err", 32'(bus.rsp_err), 32'(e_err));
    check("rsp_data", 32'(bus.rsp_data), 32'(e_data));
    check("push_cnt", 32'(n_push - p0), 32'(e_push));
    check("pop_cnt", 32'(n_pop - q0), 32'(e_pop));
    check("tos_cnt", 32'(n_tos - t0), 32'(e_tos));
    check("depth", 32'(depth), 32'(mstk.size()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    mstk.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int  p;
    bit  saw;
    logic [2:0] op;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_imm   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_strobes", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
    check("rst_din", 32'(stk_din), 32'd0);

    // POP on empty stack
    run_cmd(OpPop, 8'h00, 1'b0);
    check("t3_err", 32'(last_err), 32'd1);
    check("t3_lat", 32'(last_lat), 32'd1);

    // 5 - 3
    run_cmd(OpPush, 8'h05, 1'b0);
    run_cmd(OpPush, 8'h03, 1'b0);
    run_cmd(OpSub, 8'h00, 1'b0);
    check("t2_sub", 32'(last_data), 32'h02);
    check("t2_lat", 32'(last_lat), 32'd6);
    check("t2_depth", 32'(depth), 32'd1);

    // NOT / TOS / POP
    do_reset();
    run_cmd(OpPush, 8'hA5, 1'b0);
    run_cmd(OpNot, 8'h00, 1'b0);
    check("t5_not", 32'(last_data), 32'h5A);
    check("t5_not_lat", 32'(last_lat), 32'd4);
    run_cmd(OpTos, 8'h00, 1'b0);
    check("t5_tos", 32'(last_data), 32'h5A);
    check("t5_tos_lat", 32'(last_lat), 32'd3);
    check("t5_depth1", 32'(depth), 32'd1);
    run_cmd(OpPop, 8'h00, 1'b0);
    check("t5_pop", 32'(last_data), 32'h5A);
    check("t5_depth0", 32'(depth), 32'd0);

    // Fill to capacity, then overflow
    for (int i = 0; i < 31; i++) run_cmd(OpPush, 8'(i), 1'b0);
    check("t4_full", 32'(depth), 32'd31);
    run_cmd(OpPush, 8'h77, 1'b0);
    check("t4_ovf_err", 32'(last_err), 32'd1);
    check("t4_ovf_depth", 32'(depth), 32'd31);

    // Modulo add
    do_reset();
    run_cmd(OpPush, 8'hFF, 1'b0);
    run_cmd(OpPush, 8'h02, 1'b0);
    run_cmd(OpAdd, 8'h00, 1'b0);
    check("t4_add_wrap", 32'(last_data), 32'h01);

    // Reset during WAIT2 of an ADD
    do_reset();
    run_cmd(OpPush, 8'h07, 1'b0);
    run_cmd(OpPush, 8'h09, 1'b0);
    while (!bus.cmd_ready) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OpAdd;
    bus.cmd_imm   = '0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    p = n_push;
    rst_n = 1'b0;
    #1;
    check("t6_depth_in_rst", 32'(depth), 32'd0);
    saw = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1'b1;
    end
    mstk.delete();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1'b1;
    end
    check("t6_no_rsp", 32'(saw), 32'd0);
    check("t6_no_push", 32'(n_push - p), 32'd0);
    check("t6_depth", 32'(depth), 32'd0);
    run_cmd(OpPop, 8'h00, 1'b0);
    check("t6_pop_err", 32'(last_err), 32'd1);

    // Randomized traffic: push-heavy phase then drain-heavy phase
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 150; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 9) < ((ph == 0) ? 6 : 2)) op = OpPush;
        else op = 3'($urandom_range(1, 7));
        run_cmd(op, W'($urandom), 1'($urandom));
      end
    end

    check("strobe_protocol", 32'(n_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
